// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : wisc_pkg
//  Purpose  : Shared opcode, condition-code and flag-index constants for the
//             ALU result stage, plus helpers that classify opcodes by which
//             condition flags they update.
//  Revision : 1.0  initial release
// ============================================================================
package wisc_pkg;

  // ALU opcodes. Any opcode with bit OP_MEM_MSB set is memory, branch or
  // load-immediate and never touches the flags.
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam int         OP_MEM_MSB = 3;

  // Branch condition codes.
  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OV     = 3'b110;
  localparam logic [2:0] CC_ALWAYS = 3'b111;

  // Bit positions inside the packed flag register.
  localparam int FLG_Z     = 2;
  localparam int FLG_V     = 1;
  localparam int FLG_N     = 0;
  localparam int NUM_FLAGS = 3;

  // ADD/SUB refresh the full Z/V/N set.
  function automatic logic sets_all_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Logic and shift ops refresh Z only; ADD/SUB refresh it as well.
  function automatic logic sets_z_flag(input logic [3:0] op);
    return sets_all_flags(op) || (op == OP_XOR) || (op == OP_SLL) ||
           (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
//  Module   : flag_unit
//  Purpose  : Holds the committed Z/V/N condition flags, updates them per
//             opcode class on accepted beats, and evaluates the branch
//             condition combinationally from the committed flags.
//  Ports    : clk, rst        clock / synchronous active-high reset
//             accept          beat accepted this cycle (valid, no stall/flush)
//             op              opcode of the presented instruction
//             sum             saturated ALU result
//             ovfl            adder overflow indication
//             cond            branch condition code
//             flag_z/v/n      committed flags
//             br_taken        condition result from committed flags
//  Revision : 1.0  initial release
// ============================================================================
module flag_unit
  import wisc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] sum,
  input  logic             ovfl,
  input  logic [2:0]       cond,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             br_taken
);

  logic [NUM_FLAGS-1:0] flags;
  logic                 upd_all;
  logic                 upd_z;

  always_comb begin
    upd_all = accept & sets_all_flags(op);
    upd_z   = accept & sets_z_flag(op);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else begin
      if (upd_z) begin
        flags[FLG_Z] <= (sum == '0);
      end
      if (upd_all) begin
        flags[FLG_V] <= ovfl;
        flags[FLG_N] <= sum[WIDTH-1];
      end
    end
  end

  assign flag_z = flags[FLG_Z];
  assign flag_v = flags[FLG_V];
  assign flag_n = flags[FLG_N];

  // Only committed flags feed the mux, so a branch issued alongside a
  // flag-setting op sees the previous flags.
  always_comb begin
    br_taken = 1'b1;
    case (cond)
      CC_NE:   br_taken = ~flag_z;
      CC_EQ:   br_taken = flag_z;
      CC_GT:   br_taken = ~flag_z & ~flag_n;
      CC_LT:   br_taken = flag_n;
      CC_GE:   br_taken = flag_z | (~flag_z & ~flag_n);
      CC_LE:   br_taken = flag_n | flag_z;
      CC_OV:   br_taken = flag_v;
      default: br_taken = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_stage
//  Purpose  : EX/MEM result register behind the saturating add/sub unit.
//             Captures result, opcode and valid on accepted beats and hosts
//             the condition-flag unit that drives branch resolution.
//  Ports    : clk, rst        clock / synchronous active-high reset
//             valid_in        instruction result presented
//             op_in           opcode of presented instruction
//             sum_in          already-saturated ALU result
//             ovfl_in         adder overflow (ADD/SUB only)
//             stall           hold all state
//             flush           squash presented instruction
//             cond_in         branch condition code
//             result_q/op_q/valid_q   registered pipeline outputs
//             flag_z/v/n      committed flags
//             br_taken        combinational branch decision
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_stage
  import wisc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             ovfl_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       cond_in,
  output logic [WIDTH-1:0] result_q,
  output logic             valid_q,
  output logic [3:0]       op_q,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             br_taken
);

  logic accept;

  assign accept = valid_in & ~stall & ~flush;

  // Result and opcode only load on accepted beats; on squashed or empty
  // cycles they keep the last committed values, which downstream ignores
  // because valid_q is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      op_q     <= '0;
      valid_q  <= 1'b0;
    end else if (!stall) begin
      valid_q <= accept;
      if (accept) begin
        result_q <= sum_in;
        op_q     <= op_in;
      end
    end
  end

  flag_unit #(
    .WIDTH (WIDTH)
  ) u_flag_unit (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .op       (op_in),
    .sum      (sum_in),
    .ovfl     (ovfl_in),
    .cond     (cond_in),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n),
    .br_taken (br_taken)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_stage
//  Purpose  : Self-checking bench for alu_result_stage: directed scenarios
//             followed by randomized traffic, compared against a behavioural
//             model of the stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [3:0]  op_in;
  logic [15:0] sum_in;
  logic        ovfl_in;
  logic        stall;
  logic        flush;
  logic [2:0]  cond_in;
  logic [15:0] result_q;
  logic        valid_q;
  logic [3:0]  op_q;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;
  logic        br_taken;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic        m_valid;
  logic [15:0] m_result;
  logic [3:0]  m_op;
  logic        m_known;   // result/op are architecturally defined
  logic        m_z, m_v, m_n;

  alu_result_stage #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .op_in    (op_in),
    .sum_in   (sum_in),
    .ovfl_in  (ovfl_in),
    .stall    (stall),
    .flush    (flush),
    .cond_in  (cond_in),
    .result_q (result_q),
    .valid_q  (valid_q),
    .op_q     (op_q),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n),
    .br_taken (br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_br(input logic [2:0] cc);
    case (cc)
      3'd0: return !m_z;
      3'd1: return m_z;
      3'd2: return !m_z && !m_n;
      3'd3: return m_n;
      3'd4: return m_z || (!m_z && !m_n);
      3'd5: return m_n || m_z;
      3'd6: return m_v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_result = 0; m_op = 0; m_known = 1;
    m_z = 0; m_v = 0; m_n = 0;
  endtask

  // One clock: apply inputs, check the combinational branch against the
  // pre-edge flags, clock, then check the registered state.
  task automatic step(input logic r, input logic v, input logic [3:0] o,
                      input logic [15:0] s, input logic ov, input logic st,
                      input logic fl, input logic [2:0] cc);
    rst = r; valid_in = v; op_in = o; sum_in = s; ovfl_in = ov;
    stall = st; flush = fl; cond_in = cc;
    #1;
    check("br_taken", {15'd0, br_taken}, {15'd0, model_br(cc)});
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!st) begin
      m_valid = v && !fl;
      if (m_valid) begin
        m_result = s; m_op = o; m_known = 1;
        if (o == 4'd0 || o == 4'd1) begin
          m_z = (s == 0); m_v = ov; m_n = (s >= 16'h8000);
        end else if (o == 4'd2 || o == 4'd4 || o == 4'd5 || o == 4'd6) begin
          m_z = (s == 0);
        end
      end else begin
        m_known = 0;
      end
    end
    #1;
    check("valid_q", {15'd0, valid_q}, {15'd0, m_valid});
    check("flag_z",  {15'd0, flag_z},  {15'd0, m_z});
    check("flag_v",  {15'd0, flag_v},  {15'd0, m_v});
    check("flag_n",  {15'd0, flag_n},  {15'd0, m_n});
    if (m_known) begin
      check("result_q", result_q, m_result);
      check("op_q", {12'd0, op_q}, {12'd0, m_op});
    end
  endtask

  logic [7:0]  reset_br_tbl;
  logic [3:0]  r_op;
  logic [15:0] r_sum;
  int          pick;

  initial begin
    reset_br_tbl = 8'b1001_0101;

    rst = 1; valid_in = 1; op_in = 4'd0; sum_in = 16'h1234; ovfl_in = 0;
    stall = 0; flush = 0; cond_in = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_result", result_q, 16'h0000);
    check("rst_valid", {15'd0, valid_q}, 16'd0);
    check("rst_flags", {13'd0, flag_z, flag_v, flag_n}, 16'd0);

    // Branch decision from reset flags for every condition code.
    for (int cc = 0; cc < 8; cc++) begin
      step(1, 1, 4'd0, 16'h1234, 0, 0, 0, cc[2:0]);
      check("rst_br_tbl", {15'd0, br_taken}, {15'd0, reset_br_tbl[cc]});
    end

    // Positive saturation.
    step(0, 1, 4'd0, 16'h7FFF, 1, 0, 0, 3'd6);
    check("possat_result", result_q, 16'h7FFF);
    check("possat_flags", {13'd0, flag_z, flag_v, flag_n}, 16'b010);
    check("possat_ov_br", {15'd0, br_taken}, 16'd1);

    // Negative then zero.
    step(0, 1, 4'd1, 16'h8000, 1, 0, 0, 3'd3);
    check("neg_flags", {13'd0, flag_z, flag_v, flag_n}, 16'b011);
    check("neg_lt_br", {15'd0, br_taken}, 16'd1);
    step(0, 1, 4'd2, 16'h0000, 0, 0, 0, 3'd1);
    check("xor_flags", {13'd0, flag_z, flag_v, flag_n}, 16'b111);
    check("xor_eq_br", {15'd0, br_taken}, 16'd1);

    // No-flag ops keep flags.
    step(0, 1, 4'd7, 16'h0000, 0, 0, 0, 3'd1);
    check("paddsb_valid", {15'd0, valid_q}, 16'd1);
    step(0, 1, 4'd8, 16'h0000, 0, 0, 0, 3'd1);
    check("mem_flags", {13'd0, flag_z, flag_v, flag_n}, 16'b111);
    check("mem_result", result_q, 16'h0000);

    // Stall holds, release captures, flush squashes, stall beats flush.
    for (int i = 0; i < 3; i++) step(0, 1, 4'd0, 16'h0005, 0, 1, 0, 3'd0);
    step(0, 1, 4'd0, 16'h0005, 0, 0, 0, 3'd0);
    check("unstall_result", result_q, 16'h0005);
    check("unstall_z", {15'd0, flag_z}, 16'd0);
    step(0, 1, 4'd0, 16'h0000, 0, 0, 1, 3'd0);
    check("flush_valid", {15'd0, valid_q}, 16'd0);
    check("flush_z", {15'd0, flag_z}, 16'd0);
    step(0, 1, 4'd0, 16'h0005, 0, 0, 0, 3'd0);
    step(0, 1, 4'd0, 16'h0000, 0, 1, 1, 3'd0);
    check("stallflush_valid", {15'd0, valid_q}, 16'd1);

    // Same-cycle branch sees old flags, next cycle sees new.
    rst = 0; valid_in = 1; op_in = 4'd0; sum_in = 16'h0000; ovfl_in = 0;
    stall = 0; flush = 0; cond_in = 3'd1;
    #1;
    check("samecyc_br_old", {15'd0, br_taken}, 16'd0);
    step(0, 1, 4'd0, 16'h0000, 0, 0, 0, 3'd1);
    step(0, 0, 4'd0, 16'h0000, 0, 0, 0, 3'd1);
    check("samecyc_br_new", {15'd0, br_taken}, 16'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r_op = 4'($urandom_range(0, 15));
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1:    r_sum = 16'h0000;
        2:       r_sum = 16'h7FFF;
        3:       r_sum = 16'h8000;
        default: r_sum = 16'($urandom);
      endcase
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 8),
           r_op, r_sum,
           1'($urandom),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0),
           3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
